// File: rtl/rtype_exec_wb.sv
// rtype_exec_wb: two-stage RV32I R-type execute/write-back unit.
// It accepts an instruction word, reads the register file (with bypass from
// the instruction currently being executed), evaluates the ALU, writes back,
// and presents the retired result, one-hot write mask and retire count.
// Optional feature: define RTYPE_MULDIV_EN to also accept MUL, MULH, MULHSU
// and MULHU (funct7 0000001, funct3 000-011).
module rtype_exec_wb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ins_valid,
  input  logic [31:0]     ins,
  output logic            ins_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] res,
  output logic [XLEN-1:0] wrt,
  output logic            wb_valid,
  output logic            illegal,
  output logic [31:0]     retire_cnt
);

  typedef enum logic [1:0] {K_BASE, K_ALT, K_MUL} kind_t;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  // Base integer ops; alt selects SUB over ADD and SRA over SRL.
  function automatic logic [XLEN-1:0] base_alu(input logic alt, input logic [2:0] f3,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [4:0]             sh;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    sh = b[4:0];
    r  = '0;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << sh;
      3'b010: r = {{(XLEN-1){1'b0}}, (sa < sb)};
      3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100: r = a ^ b;
      3'b101: begin
        // Kept as separate assignments so the signed shift is not pulled
        // into an unsigned expression context.
        if (alt) r = sa >>> sh;
        else     r = a >> sh;
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

`ifdef RTYPE_MULDIV_EN
  // Multiply family: operands are extended to 2*XLEN with the signedness of
  // each variant, so one unsigned product yields the correct bit pattern.
  function automatic logic [XLEN-1:0] mul_alu(input logic [1:0] sel,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] pa;
    logic [2*XLEN-1:0] pb;
    logic [2*XLEN-1:0] prod;
    pa   = {{XLEN{a[XLEN-1] & (sel != 2'b11)}}, a};
    pb   = {{XLEN{b[XLEN-1] & (sel == 2'b01)}}, b};
    prod = pa * pb;
    return (sel == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction
`endif

  function automatic logic [XLEN-1:0] alu(input kind_t kind, input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
`ifdef RTYPE_MULDIV_EN
    if (kind == K_MUL) return mul_alu(f3[1:0], a, b);
`endif
    return base_alu(kind == K_ALT, f3, a, b);
  endfunction

  logic [XLEN-1:0] rf [32];

  logic [6:0] opc_d;
  logic [6:0] f7_d;
  logic [2:0] f3_d;
  logic [4:0] rd_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic       legal_d;
  kind_t      kind_d;
  logic       accept;

  logic            vld_p1;
  logic [4:0]      rd_p1;
  kind_t           kind_p1;
  logic [2:0]      f3_p1;
  logic [XLEN-1:0] alu_p1;

  logic            vld_p2;
  logic [4:0]      rd_p2;
  logic [XLEN-1:0] res_p2;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign opc_d  = ins[6:0];
  assign rd_d   = ins[11:7];
  assign f3_d   = ins[14:12];
  assign rs1_d  = ins[19:15];
  assign rs2_d  = ins[24:20];
  assign f7_d   = ins[31:25];
  assign accept = ins_valid && ins_ready;

  // Decode legality and op class of the incoming word.
  always_comb begin
    legal_d = 1'b0;
    kind_d  = K_BASE;
    if (opc_d == OPC_OP) begin
      if (f7_d == 7'b0000000) begin
        legal_d = 1'b1;
      end else if (f7_d == 7'b0100000 && (f3_d == 3'b000 || f3_d == 3'b101)) begin
        legal_d = 1'b1;
        kind_d  = K_ALT;
      end
`ifdef RTYPE_MULDIV_EN
      else if (f7_d == 7'b0000001 && !f3_d[2]) begin
        legal_d = 1'b1;
        kind_d  = K_MUL;
      end
`endif
    end
  end

  // The instruction held in S1 is evaluated here; its result is both the
  // write-back value and the bypass source for the next accepted word.
  assign alu_p1 = alu(kind_p1, f3_p1, op1, op2);

  // Operand read: x0 is hard zero, then bypass, then the register file.
  always_comb begin
    rs1_val = rf[rs1_d];
    rs2_val = rf[rs2_d];
    if (rs1_d == 5'd0)                       rs1_val = '0;
    else if (vld_p1 && rd_p1 == rs1_d)       rs1_val = alu_p1;
    if (rs2_d == 5'd0)                       rs2_val = '0;
    else if (vld_p1 && rd_p1 == rs2_d)       rs2_val = alu_p1;
  end

  // Register file: reset to xi = i; written as the S1 instruction executes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= XLEN'(i);
    end else if (vld_p1 && rd_p1 != 5'd0) begin
      rf[rd_p1] <= alu_p1;
    end
  end

  // Control, valids and observable outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_ready  <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      wb_valid   <= 1'b0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
      op1        <= '0;
      op2        <= '0;
      res        <= '0;
      wrt        <= '0;
    end else begin
      ins_ready <= 1'b1;
      // accept -> S1 (decode/read)
      vld_p1    <= accept && legal_d;
      illegal   <= accept && !legal_d;
      if (accept && legal_d) begin
        op1 <= rs1_val;
        op2 <= rs2_val;
      end
      // S1 -> S2 (execute)
      vld_p2    <= vld_p1;
      // S2 -> retire
      wb_valid  <= vld_p2;
      if (vld_p2) begin
        res        <= res_p2;
        wrt        <= (rd_p2 == 5'd0) ? '0 : (XLEN'(1) << rd_p2);
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  // Datapath registers; qualified by the valids above, so no reset needed.
  always_ff @(posedge clk) begin
    // accept -> S1
    if (accept && legal_d) begin
      rd_p1   <= rd_d;
      kind_p1 <= kind_d;
      f3_p1   <= f3_d;
    end
    // S1 -> S2
    if (vld_p1) begin
      rd_p2  <= rd_p1;
      res_p2 <= alu_p1;
    end
  end

endmodule

// File: tb/tb_rtype_exec_wb.sv
// tb_rtype_exec_wb: directed bench for rtype_exec_wb with an instruction-level
// reference model (program-order register file plus fixed output latency)
// compared every cycle, and literal expectations from hand-worked examples.
module tb_rtype_exec_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ins_valid;
  logic [31:0] ins;
  logic        ins_ready;
  logic [31:0] op1, op2, res, wrt;
  logic        wb_valid, illegal;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  rtype_exec_wb #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins        (ins),
    .ins_ready  (ins_ready),
    .op1        (op1),
    .op2        (op2),
    .res        (res),
    .wrt        (wrt),
    .wb_valid   (wb_valid),
    .illegal    (illegal),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] mregs [32];
  logic        exp_ready, exp_wb, exp_ill;
  logic [31:0] exp_op1, exp_op2, exp_res, exp_wrt, exp_cnt;
  logic        p1_v, p2_v;
  logic [31:0] p1_res, p2_res;
  logic [4:0]  p1_rd, p2_rd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
    exp_ready = 1'b0; exp_wb = 1'b0; exp_ill = 1'b0;
    exp_op1 = '0; exp_op2 = '0; exp_res = '0; exp_wrt = '0; exp_cnt = '0;
    p1_v = 1'b0; p2_v = 1'b0;
    p1_res = '0; p2_res = '0; p1_rd = '0; p2_rd = '0;
  endtask

  task automatic model_exec(input logic [31:0] w, output logic ok,
                            output logic [31:0] a, output logic [31:0] b,
                            output logic [31:0] r);
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    longint      ps;
    logic [63:0] pu;
    f7 = w[31:25];
    f3 = w[14:12];
    a  = mregs[w[19:15]];
    b  = mregs[w[24:20]];
    sh = b[4:0];
    ok = 1'b0;
    if (w[6:0] == 7'h33) begin
      if (f7 == 7'h00) ok = 1'b1;
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ok = 1'b1;
`ifdef RTYPE_MULDIV_EN
      if (f7 == 7'h01 && f3 < 3'd4) ok = 1'b1;
`endif
    end
    r = '0;
    if (f7 == 7'h01) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); r = ps[63:32]; end
        3'd2: begin ps = longint'($signed(a)) * longint'({32'b0, b}); r = ps[63:32]; end
        default: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      endcase
    end else begin
      case (f3)
        3'd0: r = (f7 == 7'h20) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = (a >> sh) | ((f7 == 7'h20 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endtask

  task automatic model_step();
    logic        ok, acc;
    logic [31:0] a, b, r;
    acc     = ins_valid && exp_ready;
    exp_wb  = p2_v;
    exp_ill = 1'b0;
    if (p2_v) begin
      exp_res = p2_res;
      exp_wrt = (p2_rd == 5'd0) ? 32'd0 : (32'd1 << p2_rd);
      exp_cnt = exp_cnt + 32'd1;
    end
    p2_v = p1_v; p2_res = p1_res; p2_rd = p1_rd;
    p1_v = 1'b0;
    if (acc) begin
      model_exec(ins, ok, a, b, r);
      if (ok) begin
        exp_op1 = a;
        exp_op2 = b;
        if (ins[11:7] != 5'd0) mregs[ins[11:7]] = r;
        p1_v = 1'b1; p1_res = r; p1_rd = ins[11:7];
      end else begin
        exp_ill = 1'b1;
      end
    end
    exp_ready = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    @(posedge rst);
    forever begin
      @(negedge clk);
      check("ins_ready", {31'b0, ins_ready}, {31'b0, exp_ready});
      check("op1", op1, exp_op1);
      check("op2", op2, exp_op2);
      check("res", res, exp_res);
      check("wrt", wrt, exp_wrt);
      check("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb});
      check("illegal", {31'b0, illegal}, {31'b0, exp_ill});
      check("retire_cnt", retire_cnt, exp_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] w);
    ins       = w;
    ins_valid = 1'b1;
    @(negedge clk);
    ins_valid = 1'b0;
    ins       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] vec [12];

  initial begin
    ins = '0;
    ins_valid = 1'b0;
    vec[0]  = enc(7'h20, 5'd5,  5'd0,  3'd0, 5'd12); // sub  x12,x0,x5
    vec[1]  = enc(7'h20, 5'd1,  5'd12, 3'd5, 5'd13); // sra  x13,x12,x1
    vec[2]  = enc(7'h00, 5'd1,  5'd12, 3'd5, 5'd14); // srl  x14,x12,x1
    vec[3]  = enc(7'h00, 5'd2,  5'd12, 3'd1, 5'd15); // sll  x15,x12,x2
    vec[4]  = enc(7'h00, 5'd31, 5'd12, 3'd4, 5'd16); // xor  x16,x12,x31
    vec[5]  = enc(7'h00, 5'd8,  5'd3,  3'd6, 5'd17); // or   x17,x3,x8
    vec[6]  = enc(7'h00, 5'd31, 5'd12, 3'd7, 5'd18); // and  x18,x12,x31
    vec[7]  = enc(7'h00, 5'd0,  5'd12, 3'd2, 5'd19); // slt  x19,x12,x0
    vec[8]  = enc(7'h00, 5'd12, 5'd0,  3'd3, 5'd20); // sltu x20,x0,x12
    vec[9]  = enc(7'h00, 5'd31, 5'd1,  3'd1, 5'd21); // sll  x21,x1,x31
    vec[10] = enc(7'h20, 5'd31, 5'd21, 3'd5, 5'd22); // sra  x22,x21,x31
    vec[11] = enc(7'h20, 5'd1,  5'd1,  3'd1, 5'd23); // funct7 0100000 + funct3 001: illegal

    #2 rst = 1'b1;
    idle(3);
    check("rst ins_ready", {31'b0, ins_ready}, 32'd0);
    check("rst res", res, 32'd0);
    check("rst retire_cnt", retire_cnt, 32'd0);
    #2 rst = 1'b0;
    idle(1);
    check("ready after release", {31'b0, ins_ready}, 32'd1);

    // add x3,x1,x2
    send(32'h002081B3);
    check("add op1", op1, 32'd1);
    check("add op2", op2, 32'd2);
    idle(2);
    check("add res", res, 32'd3);
    check("add wrt", wrt, 32'h0000_0008);
    check("add wb_valid", {31'b0, wb_valid}, 32'd1);
    check("add retire_cnt", retire_cnt, 32'd1);

    // add x3,x1,x2 ; add x5,x3,x3 back-to-back
    send(32'h002081B3);
    send(32'h003182B3);
    check("dep op1 bypass", op1, 32'd3);
    idle(1);
    check("dep first res", res, 32'd3);
    idle(1);
    check("dep second res", res, 32'd6);
    check("dep second wrt", wrt, 32'h0000_0020);
    check("dep second cnt", retire_cnt, 32'd3);

    // sub x4,x1,x2 ; slt x7,x4,x1 ; sltu x7,x4,x1
    send(32'h40208233);
    send(32'h001223B3);
    check("slt op1 bypass", op1, 32'hFFFF_FFFF);
    check("slt op2", op2, 32'd1);
    send(32'h001233B3);
    check("sub res", res, 32'hFFFF_FFFF);
    idle(1);
    check("slt res", res, 32'd1);
    idle(1);
    check("sltu res", res, 32'd0);
    check("sltu cnt", retire_cnt, 32'd6);

    // add x0,x1,x2 ; add x9,x0,x0 ; addi (illegal)
    send(32'h00208033);
    send(32'h000004B3);
    check("x0 op1", op1, 32'd0);
    check("x0 op2", op2, 32'd0);
    send(32'h00000013);
    check("x0 wb_valid", {31'b0, wb_valid}, 32'd1);
    check("x0 wrt", wrt, 32'd0);
    check("addi illegal", {31'b0, illegal}, 32'd1);
    idle(1);
    check("x9 wrt", wrt, 32'h0000_0200);
    check("x9 cnt", retire_cnt, 32'd8);
    idle(1);
    check("illegal no wb", {31'b0, wb_valid}, 32'd0);
    check("illegal cnt", retire_cnt, 32'd8);

    // mixed op vectors with occasional gaps; checked by the model
    for (int i = 0; i < 12; i++) begin
      send(vec[i]);
      if (i % 4 == 3) idle(1);
    end
    idle(3);

    // reset between accept and retire
    send(32'h00108233);                         // add x4,x1,x1
    check("pre-reset op1", op1, 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid-rst wb_valid", {31'b0, wb_valid}, 32'd0);
    check("mid-rst op1", op1, 32'd0);
    check("mid-rst res", res, 32'd0);
    check("mid-rst cnt", retire_cnt, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    send(32'h00020533);                         // add x10,x4,x0
    check("x4 after reset", op1, 32'd4);
    idle(2);
    check("x10 res", res, 32'd4);
    check("x10 cnt", retire_cnt, 32'd1);

    // mul x8,x2,x2
    send(32'h02210433);
`ifdef RTYPE_MULDIV_EN
    idle(2);
    check("mul res", res, 32'd4);
    check("mul wrt", wrt, 32'h0000_0100);
    check("mul cnt", retire_cnt, 32'd2);
`else
    check("mul illegal", {31'b0, illegal}, 32'd1);
    idle(2);
    check("mul no wb", {31'b0, wb_valid}, 32'd0);
    check("mul cnt", retire_cnt, 32'd1);
`endif
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_exec_wb.md
# rtype_exec_wb

Two-stage execute/write-back unit that consumes the instruction word stream produced by the instruction memory stage and retires RV32I R-type instructions. It holds the 32×32 architectural register file, reads operands, computes the ALU result and writes it back, bypassing so back-to-back dependent instructions never stall. Its `op1`/`op2`/`res`/`wrt` outputs mirror the datapath observation signals the team's single-cycle R-type bench already probes.

## Interface
- `XLEN`, 32: datapath and register width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `ins_valid` input 1: `ins` holds an instruction this cycle.
- `ins` input 32: instruction word from the instruction memory stage.
- `ins_ready` output 1: stage accepts `ins` this cycle.
- `op1` output 32: rs1 value of the instruction in S1.
- `op2` output 32: rs2 value of the instruction in S1.
- `res` output 32: registered result of the last retired instruction.
- `wrt` output 32: one-hot register write mask of the last retired instruction; all zero when rd = x0.
- `wb_valid` output 1: one-cycle pulse; an instruction retired this cycle.
- `illegal` output 1: one-cycle pulse; an unsupported instruction was dropped.
- `retire_cnt` output 32: count of retired instructions.

## Operation
- Acceptance: `ins_valid && ins_ready` at a rising edge.
  - `ins_ready` is 0 while `rst` is high and 1 from the first edge after release.
  - There is no downstream backpressure.
- Decode at accept: opcode must be 7'b0110011.
  - funct7 0000000 is legal with every funct3: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 0100000 is legal with funct3 000 (SUB) or 101 (SRA).
  - Anything else is dropped: S1 stays empty and `illegal` pulses in the next cycle.
- S1 (decode/read) captures rd, the op select, and the operands.
  - Operands are read from the register file, with bypass from S2's ALU output when S2 is valid, S2.rd == rs, and rs != 0.
  - x0 always reads 0.
- S2 (execute/write-back) runs in the cycle after S1 holds a valid instruction.
  - The ALU result is written to `rd` (suppressed for x0) and registered into `res`.
  - `wrt` = 1 << rd, or 0 when rd = 0.
  - `wb_valid` pulses and `retire_cnt` increments. x0 writes count.
- Arithmetic:
  - Add and subtract are modulo 2^32.
  - Shift amount is rs2[4:0]; SRA sign-extends.
  - SLT compares signed, SLTU compares unsigned; both give 0 or 1.
  - `retire_cnt` wraps from 0xFFFFFFFF to 0.
- Reset values:
  - Register xi = i for i = 1..31, and x0 = 0.
  - `op1`, `op2`, `res`, `wrt`, and `retire_cnt` = 0.
  - `wb_valid`, `illegal`, and `ins_ready` = 0.
  - S1 and S2 are empty.
- Reset mid-operation: in-flight instructions are discarded with no write-back, and the register file returns to its reset values.

## Timing
- Instruction accepted at edge E. `op1`/`op2` are valid in the cycle after E. The register write, `res`, `wrt`, and `wb_valid` become visible after edge E+2. Latency is 2 cycles and throughput is 1 per cycle.
- Dependent pair A then B in consecutive cycles: B gets A's result via the S2 bypass at the same edge A writes. There is no bubble.
- Gap cycles (`ins_valid` = 0) propagate as empty stages: `wb_valid` = 0, and `res`/`wrt` hold their values.
- `op1`/`op2` hold their last values when S1 is empty.

## Configuration
- `RTYPE_MULDIV_EN`: when defined, funct7 0000001 with funct3 000–011 is legal.
  - The four ops are MUL (low 32 bits), MULH (signed×signed high), MULHSU, and MULHU.
  - Each computes single-cycle in S2 with the same latency and bypass as other ops.
- Without the macro, funct7 0000001 is illegal.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) → at E+2: `res` = 3, `wrt` = 0x00000008, `wb_valid` = 1, `retire_cnt` = 1; `op1` = 1 and `op2` = 2 at E+1.
- 0x002081B3 then `add x5,x3,x3` (0x003182B3) back-to-back → second retire has `res` = 6 and retires one cycle after the first.
- `sub x4,x1,x2` (0x40208233) → `res` = 0xFFFFFFFF. Then `slt x7,x4,x1` (0x001223B3) → `res` = 1; SLTU with the same registers → 0.
- `add x0,x1,x2` (0x00208033) → `wb_valid` = 1, `wrt` = 0, x0 still reads 0. Then `addi` word 0x00000013 → `illegal` pulse, no `wb_valid`, `retire_cnt` unchanged.
- `rst` asserted between accept and retire → no `wb_valid` and all outputs return to 0. After release, x4 reads 4.
- With `RTYPE_MULDIV_EN`, `mul x8,x2,x2` (0x02210433) → `res` = 4. Without the macro → `illegal` pulse.
